// File: rtl/mips.sv
// Multicycle 32-bit MIPS-subset core that drives an external 256Kx16 asynchronous SRAM.
// Each 32-bit word moves as two big-endian halfword bus cycles. SRAM strobes are registered.
module mips (
  input  logic        clock,
  input  logic        reset,
  output logic [17:0] addr,
  inout  wire  [15:0] data,
  output logic        wre,
  output logic        oute,
  output logic        hb_mask,
  output logic        lb_mask,
  output logic        chip_en
);

  typedef enum logic [2:0] {
    FETCH_H, FETCH_L, DECODE, EXEC, MEM_H, MEM_L, WB
  } state_t;

  state_t      state, nxt;
  logic        run;
  logic [31:0] pc, next_pc, ir, a, b, alu, alu_out, mdr;
  logic [31:0] rf [32];
  logic        drive;
  logic [15:0] wdata;

  logic [17:0] n_addr;
  logic        n_bus, n_write;
  logic [15:0] n_wdata;

  function automatic logic signed [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  logic [5:0]         op, funct;
  logic [4:0]         rs, rt, rd, dest;
  logic signed [31:0] imm_sext;
  logic               is_alu_r, is_addiu, is_lw, is_sw, is_beq, is_j;
  logic [31:0]        branch_target, wb_val;

  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm_sext = sext16(ir[15:0]);

  assign is_alu_r = (op == 6'h00) &&
                    (funct == 6'h21 || funct == 6'h23 || funct == 6'h24 ||
                     funct == 6'h25 || funct == 6'h2A);
  assign is_addiu = (op == 6'h09);
  assign is_lw    = (op == 6'h23);
  assign is_sw    = (op == 6'h2B);
  assign is_beq   = (op == 6'h04);
  assign is_j     = (op == 6'h02);

  // pc already holds PC+4 once DECODE has completed
  assign branch_target = pc + (imm_sext <<< 2);
  assign dest          = (op == 6'h00) ? rd : rt;
  assign wb_val        = is_lw ? mdr : alu_out;

  always_comb begin
    alu = 32'h0;
    if (op == 6'h00) begin
      case (funct)
        6'h21:   alu = a + b;
        6'h23:   alu = a - b;
        6'h24:   alu = a & b;
        6'h25:   alu = a | b;
        6'h2A:   alu = {31'b0, ($signed(a) < $signed(b))};
        default: alu = 32'h0;
      endcase
    end else begin
      alu = a + imm_sext;
    end
  end

  // Bus outputs are computed for the state being entered so they are registered at that edge
  always_comb begin
    nxt     = state;
    next_pc = pc;
    n_addr  = addr;
    n_bus   = 1'b0;
    n_write = 1'b0;
    n_wdata = 16'h0;
    if (!run) begin
      nxt = FETCH_H;
    end else begin
      case (state)
        FETCH_H: nxt = FETCH_L;
        FETCH_L: nxt = DECODE;
        DECODE: begin
          nxt     = EXEC;
          next_pc = pc + 32'd4;
        end
        EXEC: begin
          if (is_lw || is_sw)            nxt = MEM_H;
          else if (is_alu_r || is_addiu) nxt = WB;
          else                           nxt = FETCH_H;
          if (is_beq && a == b) next_pc = branch_target;
          if (is_j)             next_pc = {pc[31:28], ir[25:0], 2'b00};
        end
        MEM_H:   nxt = MEM_L;
        MEM_L:   nxt = is_lw ? WB : FETCH_H;
        WB:      nxt = FETCH_H;
        default: nxt = FETCH_H;
      endcase
    end
    case (nxt)
      FETCH_H: begin
        n_bus  = 1'b1;
        n_addr = next_pc[18:1];
      end
      FETCH_L: begin
        n_bus  = 1'b1;
        n_addr = pc[18:1] + 18'd1;
      end
      MEM_H: begin
        n_bus   = 1'b1;
        n_addr  = alu[18:1];
        n_write = is_sw;
        n_wdata = b[31:16];
      end
      MEM_L: begin
        n_bus   = 1'b1;
        n_addr  = alu_out[18:1] + 18'd1;
        n_write = is_sw;
        n_wdata = b[15:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= FETCH_H;
      run     <= 1'b0;
      pc      <= 32'h0;
      ir      <= 32'h0;
      a       <= 32'h0;
      b       <= 32'h0;
      alu_out <= 32'h0;
      mdr     <= 32'h0;
      addr    <= 18'h0;
      chip_en <= 1'b1;
      hb_mask <= 1'b1;
      lb_mask <= 1'b1;
      oute    <= 1'b1;
      wre     <= 1'b1;
      drive   <= 1'b0;
      wdata   <= 16'h0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    end else begin
      run     <= 1'b1;
      state   <= nxt;
      pc      <= next_pc;
      addr    <= n_addr;
      chip_en <= ~n_bus;
      hb_mask <= ~n_bus;
      lb_mask <= ~n_bus;
      oute    <= ~(n_bus & ~n_write);
      wre     <= ~n_write;
      drive   <= n_write;
      wdata   <= n_wdata;
      if (run) begin
        case (state)
          FETCH_H: ir[31:16] <= data;
          FETCH_L: ir[15:0]  <= data;
          DECODE: begin
            a <= rf[rs];
            b <= rf[rt];
          end
          EXEC:    alu_out <= alu;
          MEM_H:   if (is_lw) mdr[31:16] <= data;
          MEM_L:   if (is_lw) mdr[15:0]  <= data;
          WB:      if (dest != 5'd0) rf[dest] <= wb_val;
          default: ;
        endcase
      end
    end
  end

  assign data = drive ? wdata : 16'bz;

endmodule

// File: tb/tb_mips.sv
// Directed bench for the mips core: behavioural SRAM plus a negedge log of every bus cycle.
module tb_mips;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [17:0] addr;
  wire  [15:0] data;
  logic        wre, oute, hb_mask, lb_mask, chip_en;

  logic [15:0] mem [262144];
  int          cyc;
  int          checks = 0;
  int          errors = 0;

  typedef struct packed {
    logic [15:0] c;
    logic [17:0] a;
    logic [15:0] d;
    logic        w;
    logic        oe;
  } ent_t;
  ent_t log_q[$];

  mips dut (
    .clock(clock), .reset(reset), .addr(addr), .data(data), .wre(wre),
    .oute(oute), .hb_mask(hb_mask), .lb_mask(lb_mask), .chip_en(chip_en)
  );

  always #5 clock = ~clock;

  assign data = (!chip_en && !oute) ? mem[addr] : 16'bz;

  always @(posedge clock) begin
    if (!chip_en && !wre) mem[addr] = data;
  end

  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge clock) begin
    if (!reset && !chip_en) log_q.push_back({cyc[15:0], addr, data, wre, oute});
  end

  task automatic begin_test();
    reset = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 262144; i++) mem[i] = 16'h0;
  endtask

  task automatic put_word(input logic [31:0] ba, input logic [31:0] w);
    mem[ba[18:1]]         = w[31:16];
    mem[ba[18:1] + 18'd1] = w[15:0];
  endtask

  task automatic run_cycles(input int n);
    @(negedge clock);
    reset = 1'b0;
    log_q.delete();
    repeat (n) @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic get_writes(output ent_t wq[$]);
    wq.delete();
    foreach (log_q[i]) if (!log_q[i].w) wq.push_back(log_q[i]);
  endtask

  task automatic test_reset();
    begin_test();
    put_word(32'h0, 32'h24011234);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2;
    checks++;
    if (addr !== 18'h1 || oute !== 1'b0) begin
      errors++; $display("FAIL pre_reset_fetch addr=%h oute=%b want addr=1 oute=0", addr, oute);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({chip_en, wre, oute, hb_mask, lb_mask} !== 5'b11111 || addr !== 18'h0) begin
      errors++; $display("FAIL async_reset strobes=%b addr=%h want 11111 addr=0",
                         {chip_en, wre, oute, hb_mask, lb_mask}, addr);
    end
    @(posedge clock);
    #1;
    checks++;
    if (chip_en !== 1'b1) begin
      errors++; $display("FAIL reset_hold chip_en=%b want 1", chip_en);
    end
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (addr !== 18'h0 || {chip_en, oute, wre, hb_mask, lb_mask} !== 5'b00100) begin
      errors++; $display("FAIL first_fetch addr=%h strobes=%b want addr=0 strobes=00100",
                         addr, {chip_en, oute, wre, hb_mask, lb_mask});
    end
    @(posedge clock);
    #1;
    checks++;
    if (addr !== 18'h1 || chip_en !== 1'b0 || oute !== 1'b0) begin
      errors++; $display("FAIL second_fetch addr=%h chip_en=%b oute=%b want 1 0 0", addr, chip_en, oute);
    end
  endtask

  task automatic test_addiu_sw();
    ent_t wq[$];
    begin_test();
    put_word(32'h0, 32'h24011234);
    put_word(32'h4, 32'hAC010040);
    run_cycles(14);
    get_writes(wq);
    checks++;
    if (wq.size() != 2) begin
      errors++; $display("FAIL sw_count got %0d want 2", wq.size());
    end else begin
      checks++;
      if (wq[0].a !== 18'h20 || wq[0].d !== 16'h0000 || wq[0].oe !== 1'b1 || wq[0].c !== 16'd10) begin
        errors++; $display("FAIL sw_high addr=%h data=%h oute=%b cyc=%0d want 20 0000 1 10",
                           wq[0].a, wq[0].d, wq[0].oe, wq[0].c);
      end
      checks++;
      if (wq[1].a !== 18'h21 || wq[1].d !== 16'h1234 || wq[1].oe !== 1'b1 || wq[1].c !== 16'd11) begin
        errors++; $display("FAIL sw_low addr=%h data=%h oute=%b cyc=%0d want 21 1234 1 11",
                           wq[1].a, wq[1].d, wq[1].oe, wq[1].c);
      end
    end
  endtask

  task automatic test_load_use();
    ent_t wq[$];
    int   rd_ok;
    begin_test();
    put_word(32'h40, 32'hDEADBEEF);
    put_word(32'h0, 32'h8C020040);
    put_word(32'h4, 32'h00421821);
    put_word(32'h8, 32'hAC030044);
    run_cycles(22);
    rd_ok = 0;
    foreach (log_q[i]) begin
      if (log_q[i].c == 16'd5 && log_q[i].a == 18'h20 && !log_q[i].oe && log_q[i].w) rd_ok++;
      if (log_q[i].c == 16'd6 && log_q[i].a == 18'h21 && !log_q[i].oe && log_q[i].w) rd_ok++;
    end
    checks++;
    if (rd_ok != 2) begin
      errors++; $display("FAIL lw_reads matched=%0d want 2", rd_ok);
    end
    get_writes(wq);
    checks++;
    if (wq.size() != 2) begin
      errors++; $display("FAIL load_use_count got %0d want 2", wq.size());
    end else begin
      checks++;
      if (wq[0].a !== 18'h22 || wq[0].d !== 16'hBD5B) begin
        errors++; $display("FAIL load_use_high addr=%h data=%h want 22 BD5B", wq[0].a, wq[0].d);
      end
      checks++;
      if (wq[1].a !== 18'h23 || wq[1].d !== 16'h7DDE) begin
        errors++; $display("FAIL load_use_low addr=%h data=%h want 23 7DDE", wq[1].a, wq[1].d);
      end
    end
  endtask

  task automatic test_branch();
    ent_t wq[$];
    int   gap, f5, f14;
    begin_test();
    put_word(32'h0,  32'h10000002);
    put_word(32'h4,  32'hAC000060);
    put_word(32'h8,  32'hAC000060);
    put_word(32'hC,  32'h24010001);
    put_word(32'h10, 32'h10200005);
    run_cycles(16);
    gap = 0; f5 = 0; f14 = 0;
    foreach (log_q[i]) begin
      if (log_q[i].c == 16'd3 || log_q[i].c == 16'd4) gap++;
      if (log_q[i].c == 16'd5 && log_q[i].a == 18'h6 && !log_q[i].oe) f5++;
      if (log_q[i].c == 16'd14 && log_q[i].a == 18'hA && !log_q[i].oe) f14++;
    end
    checks++;
    if (gap != 0) begin
      errors++; $display("FAIL beq_idle bus_cycles=%0d want 0", gap);
    end
    checks++;
    if (f5 != 1) begin
      errors++; $display("FAIL beq_taken_fetch matched=%0d want 1 (addr 6 at cycle 5)", f5);
    end
    checks++;
    if (f14 != 1) begin
      errors++; $display("FAIL beq_not_taken_fetch matched=%0d want 1 (addr A at cycle 14)", f14);
    end
    get_writes(wq);
    checks++;
    if (wq.size() != 0) begin
      errors++; $display("FAIL beq_skipped_sw writes=%0d want 0", wq.size());
    end
  endtask

  task automatic test_jump();
    ent_t wq[$];
    int   f15;
    begin_test();
    put_word(32'h0,   32'h2405FFFF);
    put_word(32'h4,   32'h24060001);
    put_word(32'h8,   32'h08000100);
    put_word(32'h400, 32'h00A6202A);
    put_word(32'h404, 32'hAC040048);
    run_cycles(28);
    f15 = 0;
    foreach (log_q[i])
      if (log_q[i].c == 16'd15 && log_q[i].a == 18'h200 && !log_q[i].oe) f15++;
    checks++;
    if (f15 != 1) begin
      errors++; $display("FAIL jump_fetch matched=%0d want 1 (addr 200 at cycle 15)", f15);
    end
    get_writes(wq);
    checks++;
    if (wq.size() != 2) begin
      errors++; $display("FAIL slt_count got %0d want 2", wq.size());
    end else begin
      checks++;
      if (wq[0].a !== 18'h24 || wq[0].d !== 16'h0000 || wq[1].a !== 18'h25 || wq[1].d !== 16'h0001) begin
        errors++; $display("FAIL slt_result got %h:%h %h:%h want 24:0000 25:0001",
                           wq[0].a, wq[0].d, wq[1].a, wq[1].d);
      end
    end
  endtask

  task automatic test_alu();
    ent_t        wq[$];
    logic [17:0] ea [6];
    logic [15:0] ed [6];
    ea = '{18'h28, 18'h29, 18'h2A, 18'h2B, 18'h2C, 18'h2D};
    ed = '{16'hFFFF, 16'hD3B4, 16'h0000, 16'h0C30, 16'h0000, 16'h3FFC};
    begin_test();
    put_word(32'h0,  32'h24010FF0);
    put_word(32'h4,  32'h24023C3C);
    put_word(32'h8,  32'h00221823);
    put_word(32'hC,  32'h00222024);
    put_word(32'h10, 32'h00222825);
    put_word(32'h14, 32'hAC030050);
    put_word(32'h18, 32'hAC040054);
    put_word(32'h1C, 32'hAC050058);
    run_cycles(48);
    get_writes(wq);
    checks++;
    if (wq.size() != 6) begin
      errors++; $display("FAIL alu_count got %0d want 6", wq.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (wq[i].a !== ea[i] || wq[i].d !== ed[i]) begin
          errors++; $display("FAIL alu_write%0d got %h:%h want %h:%h", i, wq[i].a, wq[i].d, ea[i], ed[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_addiu_sw();
    test_load_use();
    test_branch();
    test_jump();
    test_alu();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
